// File: rtl/nested_isqrt_chain_fsm.sv
// Sequencer for res = isqrt(t0 + isqrt(t1 + ... isqrt(t[N-1]))) over one shared isqrt unit.
// One request in flight at a time; the result is held until the next completion or reset.
module nested_isqrt_chain_fsm #(
  parameter int N_TERMS = 3,
  parameter int W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_vld_i,
  output logic                 arg_rdy_o,
  input  logic [N_TERMS*W-1:0] args_i,
  output logic                 res_vld_o,
  output logic [W-1:0]         res_o,
  output logic                 isqrt_x_vld_o,
  output logic [W-1:0]         isqrt_x_o,
  input  logic                 isqrt_y_vld_i,
  input  logic [W/2-1:0]       isqrt_y_i
);

  // state  | meaning
  // S_IDLE | ready for a new operand set
  // S_WAIT | isqrt of term idx_q outstanding
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int IDXW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_TERMS - 1);

  logic [0:0]           state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [N_TERMS*W-1:0] opreg_q, opreg_d;
  logic [W-1:0]         res_q, res_d;
  logic                 res_vld_q, res_vld_d;

  logic         accept;
  logic         resp;
  logic         last_resp;
  logic [W-1:0] y_ext;
  logic [W-1:0] next_term;

  assign y_ext     = {{(W - W/2){1'b0}}, isqrt_y_i};
  assign accept    = arg_vld_i && (state_q == S_IDLE);
  assign resp      = isqrt_y_vld_i && (state_q == S_WAIT);
  assign last_resp = resp && (idx_q == '0);

  // Term idx_q-1 of the captured set; unused when idx_q is zero.
  always_comb begin
    next_term = '0;
    for (int i = 0; i < N_TERMS - 1; i++) begin
      if (idx_q == IDXW'(i + 1)) next_term = opreg_q[i*W +: W];
    end
  end

  // The first request comes straight from the port so it issues in the accept cycle.
  assign isqrt_x_vld_o = accept || (resp && !last_resp);
  assign isqrt_x_o     = accept ? args_i[(N_TERMS-1)*W +: W] : next_term + y_ext;

  assign arg_rdy_o = (state_q == S_IDLE);
  assign res_vld_o = res_vld_q;
  assign res_o     = res_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    opreg_d   = opreg_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    if (accept) begin
      opreg_d = args_i;
      idx_d   = IDX_LAST;
      state_d = S_WAIT;
    end else if (resp) begin
      if (idx_q == '0) begin
        res_d     = y_ext;
        res_vld_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      opreg_q   <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      opreg_q   <= opreg_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

endmodule

// File: tb/tb_nested_isqrt_chain_fsm.sv
// Bench for nested_isqrt_chain_fsm: three instances (N=3, N=1, N=2) sharing clk/rst,
// each served by a behavioural isqrt unit with fixed or random latency.
module tb_nested_isqrt_chain_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_arg_vld, b_arg_vld, c_arg_vld;
  wire         a_arg_rdy, b_arg_rdy, c_arg_rdy;
  logic [95:0] a_args;
  logic [31:0] b_args;
  logic [63:0] c_args;
  wire         a_res_vld, b_res_vld, c_res_vld;
  wire  [31:0] a_res, b_res, c_res;

  wire  [2:0]       x_vld;
  wire  [2:0][31:0] x;
  logic [2:0]       y_vld;
  logic [2:0][15:0] y;

  nested_isqrt_chain_fsm #(.N_TERMS(3), .W(32)) u_a (
    .clk(clk), .rst(rst), .arg_vld_i(a_arg_vld), .arg_rdy_o(a_arg_rdy), .args_i(a_args),
    .res_vld_o(a_res_vld), .res_o(a_res), .isqrt_x_vld_o(x_vld[0]), .isqrt_x_o(x[0]),
    .isqrt_y_vld_i(y_vld[0]), .isqrt_y_i(y[0]));

  nested_isqrt_chain_fsm #(.N_TERMS(1), .W(32)) u_b (
    .clk(clk), .rst(rst), .arg_vld_i(b_arg_vld), .arg_rdy_o(b_arg_rdy), .args_i(b_args),
    .res_vld_o(b_res_vld), .res_o(b_res), .isqrt_x_vld_o(x_vld[1]), .isqrt_x_o(x[1]),
    .isqrt_y_vld_i(y_vld[1]), .isqrt_y_i(y[1]));

  nested_isqrt_chain_fsm #(.N_TERMS(2), .W(32)) u_c (
    .clk(clk), .rst(rst), .arg_vld_i(c_arg_vld), .arg_rdy_o(c_arg_rdy), .args_i(c_args),
    .res_vld_o(c_res_vld), .res_o(c_res), .isqrt_x_vld_o(x_vld[2]), .isqrt_x_o(x[2]),
    .isqrt_y_vld_i(y_vld[2]), .isqrt_y_i(y[2]));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  logic [2:0]  pend = '0;
  logic [2:0]  spur = '0;
  logic [2:0]  lat_rand = '0;
  int          fix_lat = 1;
  int          cnt[3];
  logic [15:0] val[3];
  int          overlap[3];
  int          reqn[3];
  logic [31:0] reqv[3][64];

  function automatic logic [15:0] isqrt32(input logic [31:0] v);
    longint r = 0;
    longint c;
    for (int b = 15; b >= 0; b--) begin
      c = r | (longint'(1) << b);
      if (c * c <= longint'(v)) r = c;
    end
    return r[15:0];
  endfunction

  function automatic logic [15:0] chain(input logic [31:0] t[3], input int n);
    logic [15:0] acc;
    logic [31:0] sum;
    acc = isqrt32(t[n-1]);
    for (int i = n - 2; i >= 0; i--) begin
      sum = t[i] + {16'b0, acc};
      acc = isqrt32(sum);
    end
    return acc;
  endfunction

  // isqrt unit model: response driven at the falling edge, requests sampled 1 time unit later.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      y_vld[k] = spur[k];
      y[k]     = 16'($urandom);
      if (pend[k]) begin
        if (cnt[k] <= 1) begin
          y_vld[k] = 1'b1;
          y[k]     = val[k];
          pend[k]  = 1'b0;
        end else begin
          cnt[k] = cnt[k] - 1;
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      if (x_vld[k]) begin
        if (pend[k]) overlap[k] = overlap[k] + 1;
        reqv[k][reqn[k] % 64] = x[k];
        reqn[k] = reqn[k] + 1;
        pend[k] = 1'b1;
        cnt[k]  = lat_rand[k] ? int'($urandom_range(16, 1)) : fix_lat;
        val[k]  = isqrt32(x[k]);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_cmp++; if (a_res_vld !== 1'b0) begin n_bad++; $display("FAIL reset_a_res_vld got=%b want=0", a_res_vld); end
    n_cmp++; if (a_res !== 32'd0) begin n_bad++; $display("FAIL reset_a_res got=%0d want=0", a_res); end
    n_cmp++; if (a_arg_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_a_arg_rdy got=%b want=1", a_arg_rdy); end
    n_cmp++; if (b_res_vld !== 1'b0) begin n_bad++; $display("FAIL reset_b_res_vld got=%b want=0", b_res_vld); end
    n_cmp++; if (b_arg_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_b_arg_rdy got=%b want=1", b_arg_rdy); end
    n_cmp++; if (c_res !== 32'd0) begin n_bad++; $display("FAIL reset_c_res got=%0d want=0", c_res); end
    n_cmp++; if (x_vld !== 3'b000) begin n_bad++; $display("FAIL reset_x_vld got=%b want=000", x_vld); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_three_terms();
    logic [31:0] t[3];
    int base, nres, lat;
    t = '{32'd13, 32'd5, 32'd16};
    fix_lat = 1;
    base = reqn[0];
    nres = 0;
    lat = -1;
    @(negedge clk);
    a_arg_vld = 1'b1;
    a_args = {t[2], t[1], t[0]};
    exp_q.push_back({16'b0, chain(t, 3)});
    #2;
    n_cmp++; if (x_vld[0] !== 1'b1) begin n_bad++; $display("FAIL three_first_req_vld got=%b want=1", x_vld[0]); end
    n_cmp++; if (x[0] !== 32'd16) begin n_bad++; $display("FAIL three_first_req got=%0d want=16", x[0]); end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      a_arg_vld = 1'b0;
      a_args = {$urandom, $urandom, $urandom};
      #2;
      if (a_res_vld) begin
        nres++;
        if (lat < 0) lat = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL three_res unexpected result %0d", a_res);
        end else begin
          last_exp = exp_q.pop_front();
          n_cmp++; if (a_res !== last_exp) begin n_bad++; $display("FAIL three_res got=%0d want=%0d", a_res, last_exp); end
        end
      end
    end
    n_cmp++; if (nres !== 1) begin n_bad++; $display("FAIL three_res_vld_count got=%0d want=1", nres); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL three_latency got=%0d want=4", lat); end
    n_cmp++; if (reqn[0] - base !== 3) begin n_bad++; $display("FAIL three_req_count got=%0d want=3", reqn[0] - base); end
    n_cmp++; if (reqv[0][(base+1)%64] !== 32'd9) begin n_bad++; $display("FAIL three_req2 got=%0d want=9", reqv[0][(base+1)%64]); end
    n_cmp++; if (reqv[0][(base+2)%64] !== 32'd16) begin n_bad++; $display("FAIL three_req3 got=%0d want=16", reqv[0][(base+2)%64]); end
  endtask

  task automatic test_single_term();
    logic [31:0] t[3];
    int base, nres, lat, low;
    t = '{32'd81, 32'd0, 32'd0};
    fix_lat = 1;
    base = reqn[1];
    nres = 0;
    lat = -1;
    low = 0;
    @(negedge clk);
    b_arg_vld = 1'b1;
    b_args = t[0];
    exp_q.push_back({16'b0, chain(t, 1)});
    #2;
    n_cmp++; if (x[1] !== 32'd81 || x_vld[1] !== 1'b1) begin n_bad++; $display("FAIL single_req got=%0d/%b want=81/1", x[1], x_vld[1]); end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      b_arg_vld = 1'b0;
      b_args = $urandom;
      #2;
      if (!b_arg_rdy) low++;
      if (b_res_vld) begin
        nres++;
        if (lat < 0) lat = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL single_res unexpected result %0d", b_res);
        end else begin
          last_exp = exp_q.pop_front();
          n_cmp++; if (b_res !== last_exp) begin n_bad++; $display("FAIL single_res got=%0d want=%0d", b_res, last_exp); end
        end
      end
    end
    n_cmp++; if (nres !== 1) begin n_bad++; $display("FAIL single_res_vld_count got=%0d want=1", nres); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL single_latency got=%0d want=2", lat); end
    n_cmp++; if (low !== 1) begin n_bad++; $display("FAIL single_rdy_low_cycles got=%0d want=1", low); end
    n_cmp++; if (reqn[1] - base !== 1) begin n_bad++; $display("FAIL single_req_count got=%0d want=1", reqn[1] - base); end
  endtask

  task automatic test_wrap();
    logic [31:0] t[3];
    int base, nres;
    t = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    fix_lat = 2;
    base = reqn[2];
    nres = 0;
    @(negedge clk);
    c_arg_vld = 1'b1;
    c_args = {t[1], t[0]};
    exp_q.push_back({16'b0, chain(t, 2)});
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      c_arg_vld = 1'b0;
      #2;
      if (c_res_vld) begin
        nres++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL wrap_res unexpected result %0d", c_res);
        end else begin
          last_exp = exp_q.pop_front();
          n_cmp++; if (c_res !== last_exp) begin n_bad++; $display("FAIL wrap_res got=%0d want=%0d", c_res, last_exp); end
        end
      end
    end
    n_cmp++; if (nres !== 1) begin n_bad++; $display("FAIL wrap_res_vld_count got=%0d want=1", nres); end
    n_cmp++; if (reqv[2][(base+1)%64] !== 32'h0000_FFFE) begin n_bad++; $display("FAIL wrap_req2 got=%h want=0000fffe", reqv[2][(base+1)%64]); end
    fix_lat = 1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] t[3];
    int base, ov, nacc, nres, bad_b2b;
    base = reqn[0];
    ov = overlap[0];
    nacc = 0;
    nres = 0;
    bad_b2b = 0;
    lat_rand[0] = 1'b1;
    for (int i = 0; i < 3; i++) t[i] = $urandom;
    for (int cyc = 0; cyc < 3000 && nres < 20; cyc++) begin
      @(negedge clk);
      a_arg_vld = (nacc < 20);
      a_args = {t[2], t[1], t[0]};
      #2;
      if (a_res_vld) begin
        nres++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_res unexpected result %0d", a_res);
        end else begin
          last_exp = exp_q.pop_front();
          n_cmp++; if (a_res !== last_exp) begin n_bad++; $display("FAIL b2b_res got=%0d want=%0d", a_res, last_exp); end
        end
      end
      if (a_arg_vld && a_arg_rdy) begin
        if (nacc > 0 && !a_res_vld) bad_b2b++;
        exp_q.push_back({16'b0, chain(t, 3)});
        nacc++;
        for (int i = 0; i < 3; i++) t[i] = $urandom;
      end
    end
    a_arg_vld = 1'b0;
    lat_rand[0] = 1'b0;
    n_cmp++; if (nres !== 20) begin n_bad++; $display("FAIL b2b_result_count got=%0d want=20", nres); end
    n_cmp++; if (reqn[0] - base !== 60) begin n_bad++; $display("FAIL b2b_req_count got=%0d want=60", reqn[0] - base); end
    n_cmp++; if (overlap[0] - ov !== 0) begin n_bad++; $display("FAIL b2b_outstanding got=%0d want=0", overlap[0] - ov); end
    n_cmp++; if (bad_b2b !== 0) begin n_bad++; $display("FAIL b2b_accept_in_res_cycle got=%0d want=0", bad_b2b); end
  endtask

  task automatic test_spurious();
    int base, bad_v, bad_r, bad_rdy;
    base = reqn[0];
    bad_v = 0;
    bad_r = 0;
    bad_rdy = 0;
    repeat (20) @(negedge clk);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      spur[0] = (cyc < 6);
      #2;
      if (a_res_vld) bad_v++;
      if (a_res !== last_exp) bad_r++;
      if (!a_arg_rdy) bad_rdy++;
    end
    spur[0] = 1'b0;
    n_cmp++; if (reqn[0] - base !== 0) begin n_bad++; $display("FAIL spur_requests got=%0d want=0", reqn[0] - base); end
    n_cmp++; if (bad_v !== 0) begin n_bad++; $display("FAIL spur_res_vld got=%0d want=0", bad_v); end
    n_cmp++; if (bad_r !== 0) begin n_bad++; $display("FAIL spur_res_hold got=%0d want=0 (res=%0d)", bad_r, a_res); end
    n_cmp++; if (bad_rdy !== 0) begin n_bad++; $display("FAIL spur_arg_rdy got=%0d want=0", bad_rdy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] t[3];
    int base, nv, nx, nres;
    bit reached;
    t = '{32'd13, 32'd5, 32'd16};
    fix_lat = 3;
    base = reqn[0];
    reached = 0;
    nv = 0;
    nx = 0;
    nres = 0;
    @(negedge clk);
    a_arg_vld = 1'b1;
    a_args = {t[2], t[1], t[0]};
    for (int cyc = 0; cyc < 20 && !reached; cyc++) begin
      @(negedge clk);
      a_arg_vld = 1'b0;
      #2;
      if (reqn[0] - base >= 2) reached = 1;
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL rstmid_second_req got=%0d want=2", reqn[0] - base); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      #2;
      if (a_res_vld) nv++;
      if (x_vld[0]) nx++;
    end
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL rstmid_res_vld got=%0d want=0", nv); end
    n_cmp++; if (nx !== 0) begin n_bad++; $display("FAIL rstmid_late_req got=%0d want=0", nx); end
    n_cmp++; if (a_res !== 32'd0) begin n_bad++; $display("FAIL rstmid_res got=%0d want=0", a_res); end
    fix_lat = 1;
    @(negedge clk);
    a_arg_vld = 1'b1;
    a_args = {t[2], t[1], t[0]};
    exp_q.push_back({16'b0, chain(t, 3)});
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      a_arg_vld = 1'b0;
      #2;
      if (a_res_vld) begin
        nres++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rstmid_next_res unexpected result %0d", a_res);
        end else begin
          last_exp = exp_q.pop_front();
          n_cmp++; if (a_res !== last_exp) begin n_bad++; $display("FAIL rstmid_next_res got=%0d want=%0d", a_res, last_exp); end
        end
      end
    end
    n_cmp++; if (nres !== 1) begin n_bad++; $display("FAIL rstmid_next_count got=%0d want=1", nres); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0;
      val[k] = '0;
      overlap[k] = 0;
      reqn[k] = 0;
    end
    y_vld = '0;
    y = '0;
    a_arg_vld = 1'b0;
    b_arg_vld = 1'b0;
    c_arg_vld = 1'b0;
    a_args = '0;
    b_args = '0;
    c_args = '0;
    test_reset();
    test_three_terms();
    test_single_term();
    test_wrap();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nested_isqrt_chain_fsm.md
Name: nested_isqrt_chain_fsm

Overview:
- Sequencer that evaluates res = isqrt(t0 + isqrt(t1 + ... isqrt(t[N-1]))) for N_TERMS operands.
- Drives one external integer-square-root unit through a valid-only request/response pair.
- Parametrised successor of the fixed three-term formula sequencer, generalised in term count and data width.
- Adds an input ready handshake, operand capture on accept, and a result hold register.
- Sits between an operand source and a shared isqrt unit of arbitrary, variable latency.

Parameters:
- N_TERMS, 3: number of operands; must be at least 1.
- W, 32: operand/result width; must be even and at least 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- arg_vld  in  1  operand set valid.
- arg_rdy  out  1  block can accept an operand set.
- args  in  N_TERMS*W  operands; term i at args[i*W +: W].
- res_vld  out  1  one-cycle result strobe.
- res  out  W  result, zero-extended from W/2 bits.
- isqrt_x_vld  out  1  request strobe to isqrt unit.
- isqrt_x  out  W  request operand.
- isqrt_y_vld  in  1  isqrt response strobe.
- isqrt_y  in  W/2  isqrt response.

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, idx=0, res_vld=0, res=0, operand register=0.
- States:
  - IDLE, with arg_rdy=1.
  - WAIT, with arg_rdy=0; down-counter idx holds the index of the term whose isqrt is outstanding.
- Accept occurs when arg_vld && arg_rdy:
  - Capture all of args into the operand register.
  - In the same cycle, drive isqrt_x_vld=1 and isqrt_x=args[N_TERMS-1] combinationally from the port.
  - Set idx<=N_TERMS-1 and go to WAIT.
- In WAIT with isqrt_y_vld=1 and idx>0:
  - Same cycle: isqrt_x_vld=1 and isqrt_x=(opreg[idx-1] + zero-extended isqrt_y) mod 2^W (wraps, no saturation).
  - idx<=idx-1.
- In WAIT with isqrt_y_vld=1 and idx==0:
  - Next cycle: res<=zero-extended isqrt_y and res_vld=1 for exactly one cycle.
  - Go to IDLE.
- isqrt_x_vld is 0 in every other case. isqrt_x is don't-care when isqrt_x_vld=0.
- Exactly N_TERMS requests are issued per operand set. At most one request is outstanding at any time.
- isqrt_y_vld in IDLE is ignored: no state change, no output change.
- The isqrt unit may respond in any latency of 1 or more cycles.
- res holds its last value until the next result or reset; it does not clear on accept.
- Back-to-back operation: arg_rdy returns high in the cycle res_vld is asserted. A new accept in that cycle is legal.
- N_TERMS=1: the accept issues args[0]. The first response completes the operation.
- The caller may change args after the accept cycle; only the captured operands are used.
- Reset mid-operation: return to IDLE immediately. Late isqrt_y_vld pulses are then ignored; no res_vld is produced.
- Total latency: accept-to-res_vld = sum of the N_TERMS isqrt latencies + 1 cycle.

Test Plan:
- N=3, W=32, args t2=16, t1=5, t0=13, isqrt latency 1 → requests 16, 9, 16; res=4; res_vld one cycle; latency 4 cycles after accept.
- N=1, W=32, args t0=81 → single request 81; res=9; arg_rdy low only during WAIT.
- N=2, W=32, t1=0xFFFFFFFF, t0=0xFFFFFFFF → second request 0x0000FFFE (wrap); res=255.
- N=3, random isqrt latency 1..16, arg_vld held high for 20 sets → exactly 3 requests per set, never two outstanding; every res matches the reference model; accepts occur in the res_vld cycles.
- Spurious isqrt_y_vld pulses while IDLE → no requests, res unchanged, res_vld stays 0.
- rst asserted after the second request of an N=3 operation, then the pending response arrives → no res_vld; res=0; the next operation with 16, 5, 13 yields res=4.
